// File: rtl/cacheset_nway_if.sv
// rtl/cacheset_nway_if.sv - access bus between the cache controller (master) and cacheset_nway storage (slave)
interface cacheset_nway_if #(
  parameter int WAYS       = 4,
  parameter int TAG_LENGTH = 20
);
  localparam int W = $clog2(WAYS);

  logic                  en;
  logic [31:0]           a;
  logic [31:0]           d;
  logic                  we;
  logic [W-1:0]          way_sel;
  logic [TAG_LENGTH-1:0] tag_in;
  logic                  tag_we;
  logic                  dirty_set;
  logic                  inval;

  logic [31:0]           spo;
  logic                  hit;
  logic [W-1:0]          hit_way;
  logic [W-1:0]          victim_way;
  logic                  victim_dirty;
  logic [TAG_LENGTH-1:0] victim_tag;
  logic                  init_done;

  modport master (
    output en, a, d, we, way_sel, tag_in, tag_we, dirty_set, inval,
    input  spo, hit, hit_way, victim_way, victim_dirty, victim_tag, init_done
  );

  modport slave (
    input  en, a, d, we, way_sel, tag_in, tag_we, dirty_set, inval,
    output spo, hit, hit_way, victim_way, victim_dirty, victim_tag, init_done
  );
endinterface

// File: rtl/cacheset_nway.sv
// rtl/cacheset_nway.sv - N-way set-associative cache storage: data RAMs, tag/valid/dirty/replacement metadata
// Optional macro CACHESET_PLRU_EN selects tree pseudo-LRU; otherwise a per-line round-robin counter.
module cacheset_nway #(
  parameter int WAYS            = 4,
  parameter int LINES           = 128,
  parameter int WORDS_PER_BLOCK = 32,
  parameter int TAG_LENGTH      = 20
) (
  input  logic           clk,
  input  logic           rst,
  cacheset_nway_if.slave bus
);
  localparam int W     = $clog2(WAYS);
  localparam int OB    = $clog2(WORDS_PER_BLOCK);
  localparam int IB    = $clog2(LINES);
  localparam int DEPTH = LINES * WORDS_PER_BLOCK;
`ifdef CACHESET_PLRU_EN
  localparam int RB = WAYS - 1;
`else
  localparam int RB = W;
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t          state_q, state_d;
  logic [IB-1:0]   count_q, count_d;
  logic            ready;

  logic [IB-1:0]    index;
  logic [OB-1:0]    offset;
  logic [IB+OB-1:0] addr;
  logic             unused_a;

  // Metadata lives in distributed RAM, read asynchronously at the current index
  logic [WAYS-1:0][TAG_LENGTH-1:0] tag_mem   [LINES];
  logic [WAYS-1:0]                 valid_mem [LINES];
  logic [WAYS-1:0]                 dirty_mem [LINES];
  logic [RB-1:0]                   repl_mem  [LINES];

  logic [WAYS-1:0][TAG_LENGTH-1:0] tag_r;
  logic [WAYS-1:0]                 valid_r;
  logic [WAYS-1:0]                 dirty_r;
  logic [RB-1:0]                   repl_r;

  logic [WAYS-1:0] match;
  logic            hit;
  logic [W-1:0]    hit_way;
  logic            any_invalid;
  logic [W-1:0]    inv_way;
  logic [W-1:0]    policy_way;
  logic [W-1:0]    victim;

  logic            meta_en;
  logic            do_inval;
  logic            do_fill;
  logic            do_dset;
  logic            repl_upd;
  logic [RB-1:0]   repl_next;

  logic            wr_en;
  logic [31:0]     rd_data [WAYS];
  logic [W-1:0]    rd_way_q;
  logic            spo_vld_q;

  assign offset   = bus.a[OB+1:2];
  assign index    = bus.a[OB+IB+1:OB+2];
  assign addr     = {index, offset};
  assign unused_a = ^{bus.a[31:OB+IB+2], bus.a[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      INIT: begin
        count_d = count_q + IB'(1);
        if (count_q == IB'(LINES - 1)) state_d = READY;
      end
      READY: state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == READY);

  assign tag_r   = tag_mem[index];
  assign valid_r = valid_mem[index];
  assign dirty_r = dirty_mem[index];
  assign repl_r  = repl_mem[index];

  for (genvar g = 0; g < WAYS; g++) begin : g_match
    assign match[g] = valid_r[g] && (tag_r[g] == bus.tag_in);
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = W'(w);
    end
    if (!ready) hit_way = '0;
  end

  assign hit = ready && (|match);

  always_comb begin
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_r[w]) inv_way = W'(w);
    end
  end

  assign any_invalid = ~(&valid_r);

  assign meta_en  = bus.en && ready;
  assign do_inval = meta_en && bus.inval;
  assign do_fill  = meta_en && bus.tag_we && !bus.inval;
  assign do_dset  = meta_en && bus.dirty_set && !bus.inval && !bus.tag_we;

`ifdef CACHESET_PLRU_EN
  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half)
  function automatic logic [W-1:0] plru_victim(input logic [RB-1:0] bits);
    logic [W-1:0]  way;
    logic [RB-1:0] sh;
    int            node;
    way  = '0;
    node = 0;
    for (int l = 0; l < W; l++) begin
      sh   = bits >> node;
      way  = (way << 1) | W'(sh[0]);
      node = 2 * node + 1 + int'(sh[0]);
    end
    return way;
  endfunction

  function automatic logic [RB-1:0] plru_touch(input logic [RB-1:0] bits, input logic [W-1:0] way);
    logic [RB-1:0] res;
    logic [W-1:0]  sh;
    int            node;
    res  = bits;
    node = 0;
    for (int l = 0; l < W; l++) begin
      sh   = way >> (W - 1 - l);
      res  = (res & ~(RB'(1) << node)) | (RB'(~sh[0]) << node);
      node = 2 * node + 1 + int'(sh[0]);
    end
    return res;
  endfunction

  logic acc_hit;
  assign acc_hit    = meta_en && hit;
  assign policy_way = plru_victim(repl_r);
  assign repl_upd   = do_fill || acc_hit;

  always_comb begin
    repl_next = repl_r;
    if (do_fill)      repl_next = plru_touch(repl_r, bus.way_sel);
    else if (acc_hit) repl_next = plru_touch(repl_r, hit_way);
  end
`else
  assign policy_way = repl_r;
  assign repl_upd   = do_fill;
  assign repl_next  = repl_r + W'(1);
`endif

  assign victim = !ready ? '0 : (any_invalid ? inv_way : policy_way);

  always_ff @(posedge clk) begin
    if (!ready) begin
      valid_mem[count_q] <= '0;
      dirty_mem[count_q] <= '0;
      repl_mem[count_q]  <= '0;
    end else begin
      if (do_inval) begin
        valid_mem[index] <= '0;
        dirty_mem[index] <= '0;
      end else if (do_fill) begin
        tag_mem[index][bus.way_sel]   <= bus.tag_in;
        valid_mem[index][bus.way_sel] <= 1'b1;
        dirty_mem[index][bus.way_sel] <= bus.dirty_set;
      end else if (do_dset) begin
        dirty_mem[index][bus.way_sel] <= 1'b1;
      end
      if (repl_upd) repl_mem[index] <= repl_next;
    end
  end

  assign wr_en = bus.en && bus.we && ready;

  // Write-first: the word being written is forwarded to that way's read register
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    logic        wr;

    assign wr = wr_en && (bus.way_sel == W'(g));

    always_ff @(posedge clk) begin
      if (wr) mem[addr] <= bus.d;
      rd_q <= wr ? bus.d : mem[addr];
    end

    assign rd_data[g] = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_way_q  <= '0;
      spo_vld_q <= 1'b0;
    end else begin
      rd_way_q  <= hit ? hit_way : bus.way_sel;
      spo_vld_q <= 1'b1;
    end
  end

  assign bus.spo          = spo_vld_q ? rd_data[rd_way_q] : '0;
  assign bus.hit          = hit;
  assign bus.hit_way      = hit_way;
  assign bus.victim_way   = victim;
  assign bus.victim_dirty = ready && dirty_r[victim];
  assign bus.victim_tag   = ready ? tag_r[victim] : '0;
  assign bus.init_done    = ready;
endmodule
